// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS main controller (Moore FSM) with ALU decoder.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset; forces FETCH and zeroes all enables
//   op, funct    instr[31:26] / instr[5:0] from the instruction register
//   zero         ALU zero flag of the current cycle (feeds pc_en combinationally)
//   pc_en        PC enable = pc_write | (branch_take & zero_cond)
//   ir_write     IR load enable
//   mem_write    memory write enable
//   reg_write    register file write enable
//   iord         memory address select (0 PC, 1 ALUOut)
//   alusrca      ALU A select (0 PC, 1 reg A)
//   alusrcb      ALU B select (00 B, 01 4, 10 signimm, 11 signimm<<2)
//   pcsrc        PC source (00 ALU, 01 ALUOut, 10 jump target)
//   memtoreg     writeback source (0 ALUOut, 1 MDR)
//   regdst       destination register (0 rt, 1 rd)
//   alu_control  000 and, 001 or, 010 add, 110 sub, 111 slt
//   state_dbg    current state encoding
//
// Optional feature: define MC_CTRL_BNE_EN to add bne support (state BNEQ = 12).
module mc_ctrl_fsm #(
  parameter int unsigned STATE_W  = 4,
  parameter int unsigned ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_en,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic                iord,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                memtoreg,
  output logic                regdst,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [STATE_W-1:0]  state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    StFetch   = STATE_W'(0),
    StDecode  = STATE_W'(1),
    StMemAdr  = STATE_W'(2),
    StMemRd   = STATE_W'(3),
    StMemWb   = STATE_W'(4),
    StMemWr   = STATE_W'(5),
    StExecute = STATE_W'(6),
    StAluWb   = STATE_W'(7),
    StBranch  = STATE_W'(8),
    StAddiEx  = STATE_W'(9),
    StAddiWb  = STATE_W'(10),
`ifdef MC_CTRL_BNE_EN
    StJump    = STATE_W'(11),
    StBneq    = STATE_W'(12)
`else
    StJump    = STATE_W'(11)
`endif
  } state_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  localparam logic [ALUCTL_W-1:0] AluAnd = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] AluOr  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] AluAdd = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] AluSub = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] AluSlt = ALUCTL_W'(3'b111);

  state_t state_q, state_d;

  // Internal decoded enables, gated by reset before reaching the ports.
  logic pc_write, branch_take, zero_cond;
  logic ir_write_s, mem_write_s, reg_write_s;
  logic [ALUCTL_W-1:0] funct_alu;

  // Unknown funct codes fall back to add; writeback still happens.
  always_comb begin
    case (funct)
      6'b100000: funct_alu = AluAdd;
      6'b100010: funct_alu = AluSub;
      6'b100100: funct_alu = AluAnd;
      6'b100101: funct_alu = AluOr;
      6'b101010: funct_alu = AluSlt;
      default:   funct_alu = AluAdd;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef MC_CTRL_BNE_EN
          OpBne:      state_d = StBneq;
`endif
          default:    state_d = StFetch;  // illegal op executes as a nop
        endcase
      end
      StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;  // terminal states and unused encodings
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    branch_take = 1'b0;
    zero_cond   = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alu_control = AluAnd;
    case (state_q)
      StFetch: begin
        ir_write_s  = 1'b1;
        alusrcb     = 2'b01;
        alu_control = AluAdd;
        pc_write    = 1'b1;
      end
      StDecode: begin
        alusrcb     = 2'b11;
        alu_control = AluAdd;
      end
      StMemAdr, StAddiEx: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        alu_control = AluAdd;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        reg_write_s = 1'b1;
        memtoreg    = 1'b1;
      end
      StMemWr: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      StExecute: begin
        alusrca     = 1'b1;
        alu_control = funct_alu;
      end
      StAluWb: begin
        reg_write_s = 1'b1;
        regdst      = 1'b1;
      end
      StBranch: begin
        alusrca     = 1'b1;
        alu_control = AluSub;
        pcsrc       = 2'b01;
        branch_take = 1'b1;
        zero_cond   = zero;
      end
`ifdef MC_CTRL_BNE_EN
      StBneq: begin
        alusrca     = 1'b1;
        alu_control = AluSub;
        pcsrc       = 2'b01;
        branch_take = 1'b1;
        zero_cond   = ~zero;
      end
`endif
      StAddiWb: reg_write_s = 1'b1;
      StJump: begin
        pcsrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset already holds the state in FETCH, so only the enables need gating.
  assign pc_en     = ~reset & (pc_write | (branch_take & zero_cond));
  assign ir_write  = ~reset & ir_write_s;
  assign mem_write = ~reset & mem_write_s;
  assign reg_write = ~reset & reg_write_s;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: instruction-level model (op -> list of states visited,
// state -> expected output word) checked every cycle, plus directed literal checks.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BNE = 6'b000101, ILL = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op_r = 6'd0, funct_r = 6'd0;
  logic zero_r = 1'b0;

  logic pc_en, ir_write, mem_write, reg_write, iord, alusrca, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;
  int exp_state = 0;
  int seq[$];

  mc_ctrl_fsm #(.STATE_W(4), .ALUCTL_W(3)) dut (
    .clk(clk), .reset(reset), .op(op_r), .funct(funct_r), .zero(zero_r),
    .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .memtoreg(memtoreg), .regdst(regdst), .alu_control(alu_control),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] alu_of_funct(logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Output word: {pc_en, ir_write, mem_write, reg_write, iord, alusrca,
  //               alusrcb[1:0], pcsrc[1:0], memtoreg, regdst, alu_control[2:0]}
  function automatic logic [14:0] exp_out(int st, logic [5:0] f, logic z);
    logic pcw, bt, zc, irw, mw, rw, io, asa, mtr, rd;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {pcw, bt, zc, irw, mw, rw, io, asa, mtr, rd} = '0;
    asb = 2'd0; pcs = 2'd0; alu = 3'd0;
    case (st)
      0:  begin irw = 1; asb = 2'd1; alu = 3'b010; pcw = 1; end
      1:  begin asb = 2'd3; alu = 3'b010; end
      2:  begin asa = 1; asb = 2'd2; alu = 3'b010; end
      3:  io = 1;
      4:  begin rw = 1; mtr = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; alu = alu_of_funct(f); end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'd1; bt = 1; zc = z; end
      9:  begin asa = 1; asb = 2'd2; alu = 3'b010; end
      10: rw = 1;
      11: begin pcs = 2'd2; pcw = 1; end
      12: begin asa = 1; alu = 3'b110; pcs = 2'd1; bt = 1; zc = ~z; end
      default: ;
    endcase
    return {pcw | (bt & zc), irw, mw, rw, io, asa, asb, pcs, mtr, rd, alu};
  endfunction

  // States an instruction walks through, starting at FETCH.
  task automatic build_seq(input logic [5:0] o);
    case (o)
      LW:   seq = '{0, 1, 2, 3, 4};
      SW:   seq = '{0, 1, 2, 5};
      RT:   seq = '{0, 1, 6, 7};
      BEQ:  seq = '{0, 1, 8};
      ADDI: seq = '{0, 1, 9, 10};
      JMP:  seq = '{0, 1, 11};
`ifdef MC_CTRL_BNE_EN
      BNE:  seq = '{0, 1, 12};
`endif
      default: seq = '{0, 1};
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Compare process: every cycle the model is armed.
  always @(negedge clk) begin
    if (check_en) begin
      logic [14:0] got, want;
      got  = {pc_en, ir_write, mem_write, reg_write, iord, alusrca, alusrcb, pcsrc,
              memtoreg, regdst, alu_control};
      want = exp_out(exp_state, funct_r, zero_r);
      checks++;
      if (got !== want || int'(state_dbg) != exp_state) begin
        errors++;
        $display("FAIL model state=%0d exp_state=%0d outputs=%b expected=%b t=%0t",
                 state_dbg, exp_state, got, want, $time);
      end
    end
  end

  // Precondition for all tasks below: called just after a posedge, DUT in FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
    build_seq(o);
    foreach (seq[i]) begin
      op_r = o; funct_r = f; zero_r = 1'($urandom);
      exp_state = seq[i];
      check_en = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic step; @(posedge clk); #1; endtask

  task automatic measure(input string name, input logic [5:0] o, input logic [5:0] f,
                         input int want);
    int n;
    check_en = 1'b0; op_r = o; funct_r = f; zero_r = 1'b1; n = 0;
    do begin step(); n++; end while (state_dbg != 4'd0 && n < 20);
    check(name, n, want);
  endtask

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fs[6];
    int n, mwc, total;
    bit saw_j;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP, BNE, ILL};
    fs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    // Reset from time 0.
    #1 reset = 1'b1;
    #1;
    check("reset_state", state_dbg, 0);
    check("reset_enables", {pc_en, ir_write, mem_write, reg_write}, 4'b0000);
    check("reset_selects", {iord, alusrca, alusrcb, pcsrc, alu_control}, 9'b0_0_01_00_010);
    step(); step();
    reset = 1'b0;
    #1;
    check("post_reset_fetch", {state_dbg, ir_write, pc_en}, {4'd0, 2'b11});

    // lw with sub-only: walk through model.
    run_instr(LW, 6'b100000);
    run_instr(RT, 6'b100010);
    run_instr(ILL, 6'b100000);
    run_instr(BEQ, 6'b0);

    // Latencies FETCH to next FETCH.
    measure("lat_lw", LW, 6'd0, 5);
    measure("lat_sw", SW, 6'd0, 4);
    measure("lat_rtype", RT, 6'b100010, 4);
    measure("lat_addi", ADDI, 6'd0, 4);
    measure("lat_beq", BEQ, 6'd0, 3);
    measure("lat_j", JMP, 6'd0, 3);

    // beq: pc_en follows zero combinationally in BRANCH.
    op_r = BEQ; step(); step();
    check("beq_state", state_dbg, 8);
    zero_r = 1'b1; #1;
    check("beq_taken", {pc_en, pcsrc}, 3'b1_01);
    zero_r = 1'b0; #1;
    check("beq_not_taken", {pc_en, pcsrc}, 3'b0_01);
    step();
    check("beq_back_fetch", state_dbg, 0);

    // Illegal op: DECODE then FETCH, no write pulses.
    op_r = ILL; step();
    check("ill_decode", {state_dbg, mem_write, reg_write}, {4'd1, 2'b00});
    step();
    check("ill_fetch", state_dbg, 0);

    // bne opcode.
    op_r = BNE; zero_r = 1'b0; step(); step();
`ifdef MC_CTRL_BNE_EN
    check("bne_state", {state_dbg, pc_en, pcsrc}, {4'd12, 3'b1_01});
    step();
`else
    check("bne_illegal", {state_dbg, pc_en}, {4'd0, 1'b1});
`endif

    // sw then j back to back.
    total = 0; mwc = 0; saw_j = 0;
    op_r = SW;
    do begin
      if (mem_write) begin mwc++; check("sw_mw_state", state_dbg, 5); end
      step(); total++;
    end while (state_dbg != 4'd0 && total < 20);
    op_r = JMP;
    do begin
      if (state_dbg == 4'd11) begin
        saw_j = 1;
        check("j_outputs", {pcsrc, pc_en}, 3'b10_1);
      end
      step(); total++;
    end while (state_dbg != 4'd0 && total < 40);
    check("sw_j_cycles", total, 7);
    check("sw_mem_write_once", mwc, 1);
    check("j_seen", 32'(saw_j), 1);

    // Reset mid-MEMRD.
    op_r = LW; n = 0;
    do begin step(); n++; end while (state_dbg != 4'd3 && n < 10);
    check("reach_memrd", state_dbg, 3);
    #1 reset = 1'b1;
    #1;
    check("midreset_state", state_dbg, 0);
    check("midreset_enables", {pc_en, ir_write, mem_write, reg_write}, 4'b0000);
    step();
    check("midreset_held", {state_dbg, pc_en, ir_write, mem_write, reg_write}, {4'd0, 4'b0});
    reset = 1'b0;
    #1;
    check("midreset_release", {state_dbg, ir_write, pc_en}, {4'd0, 2'b11});

    // Randomized instruction stream against the model.
    repeat (300) begin
      run_instr(ops[$urandom_range(7)],
                ($urandom_range(3) == 0) ? 6'($urandom) : fs[$urandom_range(5)]);
    end
    check_en = 1'b0;
    // Unrecognised ops drawn at random as well.
    repeat (40) begin
      logic [5:0] ro;
      ro = 6'($urandom);
      run_instr(ro, 6'($urandom));
    end
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
